// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM with hold
// counter, press/release pulses and a wrapping press counter.
module key_debounce #(
   parameter int CNT_MAX        = 999_999,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic       key_level,
   output logic       key_press,
   output logic       key_release,
   output logic [7:0] press_cnt,
   output logic       key_busy
);

   localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
   localparam logic IDLE_PIN = KEY_ACTIVE_LOW;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_FILTER,
      PRESSED,
      RELEASE_FILTER
   } state_t;

   logic          s1_q, s2_q;
   logic          key_act;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic [7:0]    pcnt_q, pcnt_d;
   logic          busy_q, busy_d;

   // Two-stage synchroniser; s1 may go metastable, only s2 reads it
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_q <= IDLE_PIN;
         s2_q <= IDLE_PIN;
      end else begin
         s1_q <= key_in;
         s2_q <= s1_q;
      end
   end

   assign key_act = s2_q ^ KEY_ACTIVE_LOW;

   // State, hold counter and registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         pcnt_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         pcnt_q    <= pcnt_d;
         busy_q    <= busy_d;
      end
   end

   // Next state: any reversal in a filter state falls back to the
   // stable state; counter is cleared on every transition
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      pcnt_d    = pcnt_q;
      unique case (state_q)
         IDLE: begin
            if (key_act) begin
               state_d = PRESS_FILTER;
               cnt_d   = '0;
            end
         end
         PRESS_FILTER: begin
            if (!key_act) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
               pcnt_d  = pcnt_q + 8'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (!key_act) begin
               state_d = RELEASE_FILTER;
               cnt_d   = '0;
            end
         end
         RELEASE_FILTER: begin
            if (key_act) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == PRESS_FILTER) ||
               (state_d == RELEASE_FILTER);
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign press_cnt   = pcnt_q;
   assign key_busy    = busy_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=4 (press at edge 8),
// active-low and active-high instances.
module tb_key_debounce;

   logic       clk;
   logic       rst_n;
   logic       key;
   logic       key2;
   logic       lvl, prs, rel, bsy;
   logic [7:0] cnt;
   logic       lvl2, prs2, rel2, bsy2;
   logic [7:0] cnt2;

   int vecs;
   int errs;

   key_debounce #(.CNT_MAX(4), .KEY_ACTIVE_LOW(1'b1)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key),
      .key_level(lvl), .key_press(prs), .key_release(rel),
      .press_cnt(cnt), .key_busy(bsy)
   );

   key_debounce #(.CNT_MAX(4), .KEY_ACTIVE_LOW(1'b0)) dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n), .key_in(key2),
      .key_level(lvl2), .key_press(prs2), .key_release(rel2),
      .press_cnt(cnt2), .key_busy(bsy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      key   = 1'b1;
      key2  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [11:0] got;
      key   = 1'b1;
      key2  = 1'b0;
      rst_n = 1'b0;
      #12;
      got = {lvl, prs, rel, bsy, cnt};
      vecs++;
      if (got !== 12'h000) begin
         errs++;
         $display("FAIL reset_dut1 got=%h exp=000", got);
      end
      got = {lvl2, prs2, rel2, bsy2, cnt2};
      vecs++;
      if (got !== 12'h000) begin
         errs++;
         $display("FAIL reset_dut2 got=%h exp=000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clean_press();
      logic [10:0] got, exp;
      @(negedge clk);
      key = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         exp = {(e == 8), (e >= 8), (e >= 3 && e <= 7),
                (e >= 8) ? 8'd1 : 8'd0};
         got = {prs, lvl, bsy, cnt};
         vecs++;
         if (got !== exp) begin
            errs++;
            $display("FAIL clean_press edge%0d got=%h exp=%h",
                     e, got, exp);
         end
      end
   endtask

   task automatic test_bounce();
      int np;
      int pe;
      do_reset();
      np = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         key = (((c / 3) % 2) == 1);
         tick();
         if (prs) np++;
      end
      vecs++;
      if (np !== 0) begin
         errs++;
         $display("FAIL bounce_no_pulse got=%0d exp=0", np);
      end
      @(negedge clk);
      key = 1'b0;
      pe = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (prs) begin
            np++;
            pe = e;
         end
      end
      vecs++;
      if (np !== 1 || pe !== 8) begin
         errs++;
         $display("FAIL bounce_pulse got n=%0d edge=%0d exp n=1 edge=8",
                  np, pe);
      end
      vecs++;
      if (cnt !== 8'd1) begin
         errs++;
         $display("FAIL bounce_cnt got=%0d exp=1", cnt);
      end
   endtask

   task automatic test_release();
      logic [2:0] got, exp;
      int nr;
      int low;
      @(negedge clk);
      key = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         exp = {(e == 8), (e < 8), (e >= 3 && e <= 7)};
         got = {rel, lvl, bsy};
         vecs++;
         if (got !== exp) begin
            errs++;
            $display("FAIL release edge%0d got=%b exp=%b", e, got, exp);
         end
      end
      @(negedge clk);
      key = 1'b0;
      repeat (10) tick();
      nr = 0;
      low = 0;
      @(negedge clk);
      key = 1'b1;
      tick();
      if (rel) nr++;
      if (!lvl) low++;
      tick();
      if (rel) nr++;
      if (!lvl) low++;
      @(negedge clk);
      key = 1'b0;
      repeat (12) begin
         tick();
         if (rel) nr++;
         if (!lvl) low++;
      end
      vecs++;
      if (nr !== 0 || low !== 0) begin
         errs++;
         $display("FAIL release_glitch got rel=%0d low=%0d exp 0 0",
                  nr, low);
      end
   endtask

   task automatic test_wrap();
      int np, nr, nov;
      do_reset();
      np = 0;
      nr = 0;
      nov = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         key = 1'b0;
         repeat (10) begin
            tick();
            if (prs) np++;
            if (rel) nr++;
            if (prs && rel) nov++;
         end
         if (i == 254) begin
            vecs++;
            if (cnt !== 8'd255) begin
               errs++;
               $display("FAIL wrap_255 got=%0d exp=255", cnt);
            end
         end
         @(negedge clk);
         key = 1'b1;
         repeat (10) begin
            tick();
            if (prs) np++;
            if (rel) nr++;
            if (prs && rel) nov++;
         end
      end
      vecs++;
      if (cnt !== 8'd0) begin
         errs++;
         $display("FAIL wrap_cnt got=%0d exp=0", cnt);
      end
      vecs++;
      if (np !== 256 || nr !== 256 || nov !== 0) begin
         errs++;
         $display("FAIL wrap_pulses got p=%0d r=%0d ov=%0d exp 256 256 0",
                  np, nr, nov);
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] got;
      logic [1:0]  g2, x2;
      do_reset();
      @(negedge clk);
      key = 1'b0;
      repeat (5) tick();
      vecs++;
      if (bsy !== 1'b1) begin
         errs++;
         $display("FAIL rstmid_filter got busy=%b exp=1", bsy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      got = {lvl, prs, rel, bsy, cnt};
      vecs++;
      if (got !== 12'h000) begin
         errs++;
         $display("FAIL rstmid_async1 got=%h exp=000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         g2 = {prs, rel};
         x2 = {(e == 8), 1'b0};
         vecs++;
         if (g2 !== x2) begin
            errs++;
            $display("FAIL rstmid_req1 edge%0d got=%b exp=%b", e, g2, x2);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      got = {lvl, prs, rel, bsy, cnt};
      vecs++;
      if (got !== 12'h000) begin
         errs++;
         $display("FAIL rstmid_async2 got=%h exp=000", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         g2 = {prs, rel};
         x2 = {(e == 8), 1'b0};
         vecs++;
         if (g2 !== x2) begin
            errs++;
            $display("FAIL rstmid_req2 edge%0d got=%b exp=%b", e, g2, x2);
         end
      end
      vecs++;
      if (cnt !== 8'd1 || lvl !== 1'b1) begin
         errs++;
         $display("FAIL rstmid_final got cnt=%0d lvl=%b exp 1 1", cnt, lvl);
      end
   endtask

   task automatic test_polarity();
      logic [1:0] got, exp;
      do_reset();
      @(negedge clk);
      key2 = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         exp = {(e == 8), (e >= 8)};
         got = {prs2, lvl2};
         vecs++;
         if (got !== exp) begin
            errs++;
            $display("FAIL polarity edge%0d got=%b exp=%b", e, got, exp);
         end
      end
      vecs++;
      if (cnt2 !== 8'd1) begin
         errs++;
         $display("FAIL polarity_cnt got=%0d exp=1", cnt2);
      end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_wrap();
      test_reset_mid();
      test_polarity();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
